// File: rtl/field_nbr_store.sv
// Double-buffered Game-of-Life field: two bit planes, registered 3x3 toroidal
// neighbourhood fetch, iterator commit into the opposite plane, host load and display read.
module field_nbr_store #(
  parameter  int FIELD_W    = 64,
  parameter  int FIELD_H    = 48,
  localparam int X_ADR_SIZE = $clog2(FIELD_W),
  localparam int Y_ADR_SIZE = $clog2(FIELD_H)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_rd_field,
  input  logic [X_ADR_SIZE-1:0] i_rd_x,
  input  logic [Y_ADR_SIZE-1:0] i_rd_y,
  output logic                  o_cell_state,
  output logic [7:0]            o_nbrs,
  input  logic                  i_wr_en,
  input  logic [X_ADR_SIZE-1:0] i_wr_x,
  input  logic [Y_ADR_SIZE-1:0] i_wr_y,
  input  logic                  i_wr_state,
  input  logic                  i_host_we,
  input  logic [X_ADR_SIZE-1:0] i_host_x,
  input  logic [Y_ADR_SIZE-1:0] i_host_y,
  input  logic                  i_host_state,
  input  logic                  i_host_clr,
  input  logic [X_ADR_SIZE-1:0] i_disp_x,
  input  logic [Y_ADR_SIZE-1:0] i_disp_y,
  output logic                  o_disp_state,
  output logic                  o_host_rej
);

  localparam int CELLS = FIELD_W * FIELD_H;
  localparam int IDX_W = $clog2(CELLS);
  localparam logic [X_ADR_SIZE-1:0] X_MAX = X_ADR_SIZE'(FIELD_W - 1);
  localparam logic [Y_ADR_SIZE-1:0] Y_MAX = Y_ADR_SIZE'(FIELD_H - 1);
  localparam logic [IDX_W-1:0]      W_SZ  = IDX_W'(FIELD_W);

  // Each plane is row-major: bit index = y*FIELD_W + x.
  logic [CELLS-1:0] r_plane [2];
  logic             r_cell;
  logic [7:0]       r_nbrs;
  logic             r_disp;
  logic             r_rej;

  logic [CELLS-1:0]      w_rd_plane;
  logic [X_ADR_SIZE-1:0] w_xm, w_xp;
  logic [Y_ADR_SIZE-1:0] w_ym, w_yp;
  logic                  w_fetch_ok;
  logic                  w_cell;
  logic [7:0]            w_nbrs;
  logic                  w_disp;
  logic                  w_wr_ok, w_host_ok;

  function automatic logic in_range(input logic [X_ADR_SIZE-1:0] x,
                                    input logic [Y_ADR_SIZE-1:0] y);
    return (x <= X_MAX) && (y <= Y_MAX);
  endfunction

  function automatic logic [IDX_W-1:0] cell_idx(input logic [X_ADR_SIZE-1:0] x,
                                                input logic [Y_ADR_SIZE-1:0] y);
    return IDX_W'(y) * W_SZ + IDX_W'(x);
  endfunction

  function automatic logic get_bit(input logic [CELLS-1:0]      pl,
                                   input logic [X_ADR_SIZE-1:0] x,
                                   input logic [Y_ADR_SIZE-1:0] y);
    return in_range(x, y) ? pl[cell_idx(x, y)] : 1'b0;
  endfunction

  // Wrap by compare-and-select so non-power-of-two field sizes stay toroidal.
  always_comb begin
    w_rd_plane = r_plane[i_rd_field];
    w_xm       = (i_rd_x == '0)    ? X_MAX : i_rd_x - X_ADR_SIZE'(1);
    w_xp       = (i_rd_x == X_MAX) ? '0    : i_rd_x + X_ADR_SIZE'(1);
    w_ym       = (i_rd_y == '0)    ? Y_MAX : i_rd_y - Y_ADR_SIZE'(1);
    w_yp       = (i_rd_y == Y_MAX) ? '0    : i_rd_y + Y_ADR_SIZE'(1);
    w_fetch_ok = in_range(i_rd_x, i_rd_y);
    w_cell     = get_bit(w_rd_plane, i_rd_x, i_rd_y);
    w_nbrs     = 8'h00;
    if (w_fetch_ok) begin
      w_nbrs = {get_bit(w_rd_plane, w_xp,   w_yp),
                get_bit(w_rd_plane, i_rd_x, w_yp),
                get_bit(w_rd_plane, w_xm,   w_yp),
                get_bit(w_rd_plane, w_xp,   i_rd_y),
                get_bit(w_rd_plane, w_xm,   i_rd_y),
                get_bit(w_rd_plane, w_xp,   w_ym),
                get_bit(w_rd_plane, i_rd_x, w_ym),
                get_bit(w_rd_plane, w_xm,   w_ym)};
    end
    w_disp    = get_bit(w_rd_plane, i_disp_x, i_disp_y);
    w_wr_ok   = in_range(i_wr_x, i_wr_y);
    w_host_ok = in_range(i_host_x, i_host_y);
  end

  // Iterator commits own the storage while simulating; host traffic is refused then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_plane[0] <= '0;
      r_plane[1] <= '0;
      r_cell     <= 1'b0;
      r_nbrs     <= 8'h00;
      r_disp     <= 1'b0;
      r_rej      <= 1'b0;
    end else begin
      r_cell <= w_cell;
      r_nbrs <= w_nbrs;
      r_disp <= w_disp;
      r_rej  <= i_wr_en & (i_host_we | i_host_clr);
      if (i_wr_en) begin
        if (w_wr_ok) r_plane[~i_rd_field][cell_idx(i_wr_x, i_wr_y)] <= i_wr_state;
      end else if (i_host_clr) begin
        r_plane[0] <= '0;
        r_plane[1] <= '0;
      end else if (i_host_we && w_host_ok) begin
        r_plane[i_rd_field][cell_idx(i_host_x, i_host_y)] <= i_host_state;
      end
    end
  end

  assign o_cell_state = r_cell;
  assign o_nbrs       = r_nbrs;
  assign o_disp_state = r_disp;
  assign o_host_rej   = r_rej;

endmodule
